// File: rtl/qos_wrr_scheduler_if.sv
// qos_wrr_scheduler_if: queue-side and egress-side signals of the
// WRR dequeue scheduler, grouped with scheduler/queue modports.
interface qos_wrr_scheduler_if #(
  parameter int NUM_Q    = 4,
  parameter int DEPTH_W  = 9,
  parameter int WEIGHT_W = 4
);
  localparam int QW = $clog2(NUM_Q);

  logic [NUM_Q*DEPTH_W-1:0]  q_depth;
  logic [NUM_Q*WEIGHT_W-1:0] q_weight;
  logic                      sp_en;
  logic                      out_ready;
  logic [NUM_Q-1:0]          rd_en;
  logic [QW-1:0]             grant_id;
  logic                      grant_valid;
  logic                      busy;

  modport master (
    input  q_depth, q_weight, sp_en, out_ready,
    output rd_en, grant_id, grant_valid, busy
  );

  modport slave (
    output q_depth, q_weight, sp_en, out_ready,
    input  rd_en, grant_id, grant_valid, busy
  );
endinterface

// File: rtl/qos_wrr_scheduler.sv
// qos_wrr_scheduler: weighted round-robin dequeue scheduler with an
// optional strict-priority override for queue 0.
module qos_wrr_scheduler #(
  parameter int NUM_Q    = 4,
  parameter int DEPTH_W  = 9,
  parameter int WEIGHT_W = 4
) (
  input logic                clk,
  input logic                rst_n,
  qos_wrr_scheduler_if.master bus
);
  localparam int QW = $clog2(NUM_Q);

  typedef enum logic {IDLE, SERVE} state_t;

  state_t              state;
  logic [QW-1:0]       cur_q;
  logic [QW-1:0]       last_q;
  logic [WEIGHT_W-1:0] credit;

  logic [NUM_Q-1:0]    elig;
  logic                sel_found;
  logic [QW-1:0]       sel_q;
  logic [WEIGHT_W-1:0] sel_w;
  logic [WEIGHT_W-1:0] sel_weff;
  logic                sp_mode;
  logic                preempt;
  logic                cur_nz;
  logic                rd_go;

  // Per-queue eligibility from occupancy
  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_Q; i++) begin
      elig[i] = |bus.q_depth[i*DEPTH_W +: DEPTH_W];
    end
  end

  // Next owner: queue 0 under strict priority, else first eligible after last_q
  always_comb begin
    sel_found = 1'b0;
    sel_q     = '0;
    if (bus.sp_en && elig[0]) begin
      sel_found = 1'b1;
    end else begin
      for (int k = NUM_Q; k >= 1; k--) begin
        if (elig[last_q + QW'(k)]) begin
          sel_found = 1'b1;
          sel_q     = last_q + QW'(k);
        end
      end
    end
    sel_w    = bus.q_weight[sel_q*WEIGHT_W +: WEIGHT_W];
    sel_weff = (sel_w == '0) ? WEIGHT_W'(1) : sel_w;
  end

  // Read strobe for the current owner
  always_comb begin
    sp_mode = bus.sp_en && (cur_q == '0);
    preempt = bus.sp_en && (cur_q != '0) && elig[0];
    cur_nz  = elig[cur_q];
    rd_go   = (state == SERVE) && bus.out_ready && cur_nz &&
              (sp_mode || credit != '0) && !preempt;
    bus.rd_en        = '0;
    bus.rd_en[cur_q] = rd_go;
  end

  assign bus.grant_valid = (state == SERVE);
  assign bus.grant_id    = cur_q;
  assign bus.busy        = |elig;

  // Turn selection, credit accounting and turn exit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cur_q  <= '0;
      last_q <= QW'(NUM_Q - 1);
      credit <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sel_found) begin
            cur_q  <= sel_q;
            credit <= sel_weff;
            state  <= SERVE;
          end
        end
        SERVE: begin
          if (preempt) begin
            state <= IDLE;
          end else if (!cur_nz) begin
            state  <= IDLE;
            last_q <= cur_q;
          end else if (rd_go && !sp_mode) begin
            credit <= credit - WEIGHT_W'(1);
            if (credit == WEIGHT_W'(1)) begin
              state  <= IDLE;
              last_q <= cur_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_qos_wrr_scheduler.sv
// tb_qos_wrr_scheduler: directed tests against a turn-level WRR model
// with FIFO occupancy fed back from the scheduler's read strobes.
module tb_qos_wrr_scheduler;
  localparam int NQ = 4;
  localparam int DW = 9;
  localparam int WW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qos_wrr_scheduler_if #(.NUM_Q(NQ), .DEPTH_W(DW), .WEIGHT_W(WW)) bus ();

  qos_wrr_scheduler #(.NUM_Q(NQ), .DEPTH_W(DW), .WEIGHT_W(WW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int dep[NQ] = '{default: 0};
  int wt[NQ]  = '{default: 1};

  // Pack bench-side queue state onto the bus
  always_comb begin
    bus.q_depth  = '0;
    bus.q_weight = '0;
    for (int i = 0; i < NQ; i++) begin
      bus.q_depth[i*DW +: DW]  = DW'(dep[i]);
      bus.q_weight[i*WW +: WW] = WW'(wt[i]);
    end
  end

  int checks = 0;
  int errors = 0;

  // model: is a turn in progress, who owns it, reads left, last finished owner
  bit m_on;
  int m_owner;
  int m_left;
  int m_last;
  int m_exp_rd;
  bit m_pre;
  bit m_spm;

  logic [NQ-1:0] seen_rd;
  int rd_cnt[NQ];

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int weff(int q);
    return (wt[q] == 0) ? 1 : wt[q];
  endfunction

  function automatic int rd_idx(logic [NQ-1:0] v);
    for (int i = 0; i < NQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_on = 0;
    m_owner = 0;
    m_left = 0;
    m_last = NQ - 1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NQ; i++) rd_cnt[i] = 0;
  endtask

  task automatic compare();
    int any;
    m_exp_rd = 0;
    m_pre = 0;
    m_spm = 0;
    if (m_on) begin
      m_pre = bus.sp_en && m_owner != 0 && dep[0] > 0;
      m_spm = bus.sp_en && m_owner == 0;
      if (bus.out_ready && dep[m_owner] > 0 && (m_spm || m_left > 0) && !m_pre)
        m_exp_rd = 1 << m_owner;
    end
    any = 0;
    for (int i = 0; i < NQ; i++) if (dep[i] > 0) any = 1;
    check("rd_en", int'(bus.rd_en), m_exp_rd);
    check("grant_valid", int'(bus.grant_valid), int'(m_on));
    if (m_on) check("grant_id", int'(bus.grant_id), m_owner);
    check("busy", int'(bus.busy), any);
  endtask

  task automatic model_edge();
    if (!m_on) begin
      if (bus.sp_en && dep[0] > 0) begin
        m_on = 1;
        m_owner = 0;
        m_left = weff(0);
      end else begin
        for (int k = 1; k <= NQ; k++) begin
          int q;
          q = (m_last + k) % NQ;
          if (dep[q] > 0) begin
            m_on = 1;
            m_owner = q;
            m_left = weff(q);
            break;
          end
        end
      end
    end else if (m_pre) begin
      m_on = 0;
    end else if (dep[m_owner] == 0) begin
      m_on = 0;
      m_last = m_owner;
    end else if (m_exp_rd != 0 && !m_spm) begin
      m_left--;
      if (m_left == 0) begin
        m_on = 0;
        m_last = m_owner;
      end
    end
  endtask

  // One clock: compare in the low phase, then advance model and FIFOs
  task automatic tick();
    #1;
    compare();
    seen_rd = bus.rd_en;
    @(posedge clk);
    #1;
    model_edge();
    for (int i = 0; i < NQ; i++) begin
      if (seen_rd[i] && dep[i] > 0) dep[i]--;
      rd_cnt[i] += int'(seen_rd[i]);
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < NQ; i++) dep[i] = 0;
    repeat (3) tick();
  endtask

  int pat[12];
  int exp_pat[12] = '{-1, 0, 0, 0, -1, 1, -1, 2, 2, -1, 3, -1};

  initial begin
    bus.sp_en = 1'b0;
    bus.out_ready = 1'b1;
    model_reset();
    clear_counts();
    repeat (2) @(negedge clk);
    #1;
    check("rst_rd_en", int'(bus.rd_en), 0);
    check("rst_grant_valid", int'(bus.grant_valid), 0);
    check("rst_grant_id", int'(bus.grant_id), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: weighted rotation 3,1,2,1
    wt = '{3, 1, 2, 1};
    dep = '{100, 100, 100, 100};
    clear_counts();
    for (int c = 0; c < 44; c++) begin
      tick();
      if (c < 12) pat[c] = rd_idx(seen_rd);
    end
    for (int i = 0; i < 12; i++)
      check($sformatf("t1_pat%0d", i), pat[i], exp_pat[i]);
    check("t1_cnt_q0", rd_cnt[0], 12);
    check("t1_cnt_q1", rd_cnt[1], 4);
    check("t1_cnt_q2", rd_cnt[2], 8);
    check("t1_cnt_q3", rd_cnt[3], 4);
    drain();

    // 2: queue empties before its credit runs out
    wt = '{1, 5, 1, 1};
    dep[1] = 2;
    clear_counts();
    repeat (6) tick();
    check("t2_cnt_q1", rd_cnt[1], 2);
    check("t2_busy", int'(bus.busy), 0);
    check("t2_idle", int'(bus.grant_valid), 0);
    dep[0] = 1;
    dep[2] = 1;
    tick();
    check("t2_next_valid", int'(bus.grant_valid), 1);
    check("t2_next_id", int'(bus.grant_id), 2);
    drain();

    // 3: backpressure mid-turn
    wt = '{1, 1, 4, 1};
    dep[2] = 20;
    clear_counts();
    for (int c = 0; c < 10 && rd_cnt[2] == 0; c++) tick();
    check("t3_first_read", rd_cnt[2], 1);
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("t3_stall_cnt", rd_cnt[2], 1);
    check("t3_stall_id", int'(bus.grant_id), 2);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (!bus.grant_valid) break;
    end
    check("t3_turn_cnt", rd_cnt[2], 4);
    drain();

    // 4: strict-priority preemption of queue 3
    bus.sp_en = 1'b1;
    wt = '{1, 1, 1, 4};
    dep[3] = 20;
    clear_counts();
    for (int c = 0; c < 10 && rd_cnt[3] == 0; c++) tick();
    check("t4_first_read", rd_cnt[3], 1);
    dep[0] = 5;
    tick();
    check("t4_preempt_q3", rd_cnt[3], 1);
    tick();
    check("t4_idle_q0", rd_cnt[0], 0);
    repeat (5) tick();
    check("t4_sp_q0", rd_cnt[0], 5);
    repeat (6) tick();
    check("t4_q3_resume", rd_cnt[3], 5);
    check("t4_q3_done", int'(bus.grant_valid), 0);
    bus.sp_en = 1'b0;
    drain();

    // 5: zero weight means one read per turn, then quiet
    wt = '{1, 0, 1, 1};
    dep[1] = 10;
    clear_counts();
    repeat (10) tick();
    check("t5_half", rd_cnt[1], 5);
    repeat (10) tick();
    check("t5_all", rd_cnt[1], 10);
    clear_counts();
    repeat (10) tick();
    check("t5_quiet", rd_cnt[0] + rd_cnt[1] + rd_cnt[2] + rd_cnt[3], 0);
    check("t5_idle", int'(bus.grant_valid), 0);

    // 6: asynchronous reset in the middle of a queue 1 burst
    wt = '{1, 4, 1, 4};
    dep[1] = 20;
    dep[3] = 20;
    clear_counts();
    for (int c = 0; c < 20 && !seen_rd[1]; c++) tick();
    check("t6_q1_burst", int'(seen_rd[1]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_rd_en", int'(bus.rd_en), 0);
    check("t6_rst_valid", int'(bus.grant_valid), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    tick();
    check("t6_first_valid", int'(bus.grant_valid), 1);
    check("t6_first_id", int'(bus.grant_id), 1);
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/qos_wrr_scheduler.md
Name: qos_wrr_scheduler

Overview:
- Dequeue scheduler for the QoS queue block.
- Shares one downstream output port among NUM_Q inner FIFOs using weighted round-robin (WRR), with an optional strict-priority override for queue 0.
- Reads each queue's occupancy (depth) and drives that queue's read request (inner_queue_out), at most one read per cycle.
- Sits between the inner FIFO controllers and the egress path.

Parameters:
NUM_Q, 4, number of inner queues served (power of 2, ≥2)
DEPTH_W, 9, width of each queue depth value
WEIGHT_W, 4, width of each per-queue weight (reads per turn)

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
q_depth  input  NUM_Q*DEPTH_W  per-queue occupancy, queue i at [i*DEPTH_W +: DEPTH_W]
q_weight  input  NUM_Q*WEIGHT_W  per-queue WRR weight, queue i at [i*WEIGHT_W +: WEIGHT_W]; quasi-static
sp_en  input  1  1 = queue 0 strict priority
out_ready  input  1  downstream can accept a word this cycle
rd_en  output  NUM_Q  one-hot read strobe, bit i drives queue i inner_queue_out
grant_id  output  log2(NUM_Q)  queue currently owning the port
grant_valid  output  1  scheduler is in SERVE
busy  output  1  some queue has depth != 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, last_q=NUM_Q-1, credit=0, cur_q=0.
  - Outputs: rd_en=0, grant_id=0, grant_valid=0.
  - A reset asserted mid-burst drops the burst immediately; no further rd_en.
- Eligibility and weights:
  - Queue i is eligible when its depth != 0.
  - q_depth must reflect every rd_en pulse up to the previous edge (zero-latency pointer update).
  - Effective weight = q_weight_i, with 0 treated as 1.
- State machine (registered state, cur_q, credit[WEIGHT_W-1:0], last_q):
  - IDLE:
    - If sp_en and queue 0 eligible: cur_q=0, credit=don't-care, go to SERVE.
    - Else search from (last_q+1) mod NUM_Q upward with wrap; the first eligible queue becomes cur_q, credit=effective weight, go to SERVE.
    - If none is eligible, stay in IDLE.
  - SERVE:
    - rd_en[cur_q] = out_ready & (depth[cur_q]!=0) & (sp_mode | credit!=0). This is combinational from registered state plus inputs; no rd_en in IDLE.
    - sp_mode = sp_en & cur_q==0. In sp_mode credit is ignored and queue 0 is served until it is empty.
    - Each issued read decrements credit (non-sp_mode only); credit never underflows.
  - Exit SERVE -> IDLE at the edge where any of these holds:
    - a read issues with credit==1 (non-sp_mode);
    - depth[cur_q]==0;
    - preemption: sp_en & cur_q!=0 & depth[0]!=0, evaluated before this cycle's read (rd_en suppressed that cycle).
  - On exit, last_q=cur_q, except on preemption, where last_q is left unchanged so the preempted queue's turn restarts.
- Status outputs:
  - grant_valid=1 and grant_id=cur_q throughout SERVE.
  - busy is combinational OR of eligibility.
- Backpressure: out_ready=0 holds state, credit and cur_q; no rd_en.
- Latency and throughput:
  - A queue becoming eligible while IDLE gets its first rd_en one cycle later (IDLE select cycle, then SERVE).
  - Each turn switch costs exactly one idle cycle.
  - Back-to-back reads within a turn are one per cycle.
- sp_en changes take effect at the next IDLE decision or preemption check.
- q_weight changes take effect only at the next credit load.

Test Plan:
1. All depths=100, weights 3,1,2,1, sp_en=0, out_ready=1 -> rd_en pattern Q0,Q0,Q0,idle,Q1,idle,Q2,Q2,idle,Q3,idle, repeating; after 4 rounds per-queue read counts are 12/4/8/4.
2. Q1 depth=2, weight=5, others empty -> exactly 2 rd_en[1] pulses, then IDLE with busy=0; last_q=1, so next service starts the search at Q2.
3. Q2 serving, weight=4, out_ready low for 3 cycles after the first read -> no rd_en during the stall, grant_id=2 held, remaining 3 reads complete after out_ready returns.
4. sp_en=1, Q3 serving with credit 3, Q0 depth goes 0->5 -> Q3 rd_en stops that cycle, one idle cycle, 5 consecutive rd_en[0], then Q3 is served again with full credit.
5. Weight=0 on Q1 (depth 10) -> one read per turn; all queues empty -> stays IDLE, rd_en=0 indefinitely.
6. rst_n pulsed low asynchronously mid-burst (between edges) -> rd_en and grant_valid drop to 0 immediately; after release the first grant goes to the lowest-index eligible queue (search starts at Q0).
